bus_mem_responder: RTL

- Memory-side responder for the CPU's single-master bus.
- Accepts one transaction per `BUS_start_transaction` pulse: a read, or a write of `BUS_wdata` to `BUS_addr`.
- Answers after a configurable wait-state latency with a one-cycle `BUS_rdata_valid` or `BUS_write_done` pulse.
- Serves both instruction fetch and LW/SW data accesses: it is the memory the control logic's bus cycles terminate in.

---
 rtl/bus_mem_responder_pkg.sv | 18 +
 rtl/bus_mem_array.sv | 24 ++
 rtl/bus_mem_responder.sv | 120 ++++++++++++
 3 files changed

// File: rtl/bus_mem_responder_pkg.sv
// Shared bus definitions for the memory responder: bus mode codes and responder state encodings.
// Optional response-error output is enabled by defining BUS_RESP_ERR_EN.
package bus_mem_responder_pkg;

    localparam logic BUS_mode_READ  = 1'b0;
    localparam logic BUS_mode_WRITE = 1'b1;

    localparam logic [1:0] BUS_RESP_IDLE = 2'd0;
    localparam logic [1:0] BUS_RESP_WAIT = 2'd1;
    localparam logic [1:0] BUS_RESP_RESP = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = BUS_RESP_IDLE,
        S_WAIT = BUS_RESP_WAIT,
        S_RESP = BUS_RESP_RESP
    } resp_state_t;

endpackage

// File: rtl/bus_mem_array.sv
// DEPTH x DATA_W word storage: synchronous write, combinational read, no reset.
module bus_mem_array #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 256,
    parameter int AW     = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/bus_mem_responder.sv
// Memory-side bus responder: fixed wait-state latency, one-cycle read/write completion pulses.
// Define BUS_RESP_ERR_EN to add the BUS_err response-error output.
//
// state  | meaning
// IDLE   | ready, accepts a start strobe
// WAIT   | counting wait states down to the response
// RESP   | one-cycle response pulse; a write commits on the edge leaving it
module bus_mem_responder
    import bus_mem_responder_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              BUS_start_transaction,
    input  logic              BUS_mode,
    input  logic [ADDR_W-1:0] BUS_addr,
    input  logic [DATA_W-1:0] BUS_wdata,
    output logic [DATA_W-1:0] BUS_rdata,
    output logic              BUS_rdata_valid,
    output logic              BUS_write_done,
    output logic              BUS_busy
`ifdef BUS_RESP_ERR_EN
    ,
    output logic              BUS_err
`endif
);

    localparam int IDX_W  = ADDR_W - 2;
    localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W  = 4;

    resp_state_t       state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic              cap_mode;
    logic [ADDR_W-1:0] cap_addr;
    logic [DATA_W-1:0] cap_wdata;

    logic              eff_mode;
    logic [ADDR_W-1:0] eff_addr;
    logic [IDX_W-1:0]  eff_idx;
    logic              eff_in_range;
    logic              mem_we;
    logic [DATA_W-1:0] mem_rdata;

    // With LATENCY=1 RESP is entered straight from IDLE, so the read lookup must
    // use the live bus fields in IDLE and the captured ones afterwards.
    assign eff_mode     = (state == S_IDLE) ? BUS_mode : cap_mode;
    assign eff_addr     = (state == S_IDLE) ? BUS_addr : cap_addr;
    assign eff_idx      = eff_addr[ADDR_W-1:2];
    assign eff_in_range = (eff_idx < IDX_W'(DEPTH));

    bus_mem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (MEM_AW)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .addr  (eff_idx[MEM_AW-1:0]),
        .wdata (cap_wdata),
        .rdata (mem_rdata)
    );

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            S_IDLE: begin
                if (BUS_start_transaction) begin
                    cnt_nxt   = CNT_W'(LATENCY - 1);
                    state_nxt = (LATENCY > 1) ? S_WAIT : S_RESP;
                end
            end
            S_WAIT: begin
                cnt_nxt = cnt - 1'b1;
                if (cnt <= CNT_W'(1)) begin
                    state_nxt = S_RESP;
                end
            end
            S_RESP:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            cap_mode  <= BUS_mode_READ;
            cap_addr  <= '0;
            cap_wdata <= '0;
            BUS_rdata <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (state == S_IDLE && BUS_start_transaction) begin
                cap_mode  <= BUS_mode;
                cap_addr  <= BUS_addr;
                cap_wdata <= BUS_wdata;
            end
            if (state_nxt == S_RESP && eff_mode == BUS_mode_READ) begin
                BUS_rdata <= eff_in_range ? mem_rdata : '0;
            end
        end
    end

    assign BUS_busy        = (state != S_IDLE);
    assign BUS_rdata_valid = (state == S_RESP) && (cap_mode == BUS_mode_READ);
    assign BUS_write_done  = (state == S_RESP) && (cap_mode == BUS_mode_WRITE);
    assign mem_we          = BUS_write_done && eff_in_range;

`ifdef BUS_RESP_ERR_EN
    assign BUS_err = (state == S_RESP) && (!eff_in_range || (eff_addr[1:0] != 2'b00));
`endif

endmodule
